// File: rtl/iob_mem_wrapper_wb.sv
// iob_mem_wrapper_wb: IOb-native on-chip word memory. It sits behind a cache-style front end
// and can replace a cache back end.
//  - Writes are posted into a small buffer. The buffer drains one entry per cycle, byte-wise.
//  - Reads wait until the buffer is empty, then return data after a fixed READ_LAT cycles.
//  - The invalidate / write-buffer-empty chain is passed through.
// Ports:
//  clk_i, arst_n_i                  clock, async active-low reset
//  iob_valid_i/addr_i/wdata_i/wstrb_i   request (wstrb==0 means read)
//  iob_rdata_o/rvalid_o             registered read return, rdata is 0 unless rvalid
//  iob_ready_o                      combinational accept
//  invalidate_i/o, wtb_empty_i/o    chain signals
module iob_mem_wrapper_wb #(
  parameter int unsigned ADDR_W     = 22,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_W    = 10,
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  iob_valid_i,
  input  logic [ADDR_W-1:0]     iob_addr_i,
  input  logic [DATA_W-1:0]     iob_wdata_i,
  input  logic [DATA_W/8-1:0]   iob_wstrb_i,
  output logic [DATA_W-1:0]     iob_rdata_o,
  output logic                  iob_rvalid_o,
  output logic                  iob_ready_o,
  input  logic                  invalidate_i,
  output logic                  invalidate_o,
  input  logic                  wtb_empty_i,
  output logic                  wtb_empty_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned PTR_W  = $clog2(WBUF_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned MEM_D  = 1 << DEPTH_W;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

  logic [DEPTH_W-1:0] wb_idx_q  [WBUF_DEPTH];
  logic [DATA_W-1:0]  wb_data_q [WBUF_DEPTH];
  logic [STRB_W-1:0]  wb_strb_q [WBUF_DEPTH];

  logic [DATA_W-1:0]  mem_q [MEM_D];

  logic [READ_LAT-1:0] rv_q;
  logic [DATA_W-1:0]   rd_q [READ_LAT];

  logic               is_wr_c;
  logic               wbuf_empty_c;
  logic               wbuf_full_c;
  logic               push_c;
  logic               drain_c;
  logic               rd_acc_c;
  logic [DEPTH_W-1:0] idx_c;
  logic               unused_addr_c;

  // Request decode. Ready is held low during reset. Word index bits above DEPTH_W alias.
  assign is_wr_c       = |iob_wstrb_i;
  assign wbuf_empty_c  = (state_q == S_IDLE);
  assign wbuf_full_c   = (cnt_q == CNT_W'(WBUF_DEPTH));
  assign iob_ready_o   = arst_n_i & (is_wr_c ? !wbuf_full_c : wbuf_empty_c);
  assign push_c        = iob_valid_i & iob_ready_o & is_wr_c;
  assign rd_acc_c      = iob_valid_i & iob_ready_o & !is_wr_c;
  assign drain_c       = (state_q == S_DRAIN);
  assign idx_c         = iob_addr_i[OFF_W +: DEPTH_W];
  assign unused_addr_c = ^iob_addr_i;

  // Chain pass-through
  assign invalidate_o = invalidate_i;
  assign wtb_empty_o  = wtb_empty_i & wbuf_empty_c;

  // Next-state logic: buffer pointers, occupancy and the IDLE/DRAIN FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(push_c) - CNT_W'(drain_c);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_c)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (drain_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case (state_q)
      S_IDLE:  if (push_c) state_d = S_DRAIN;
      S_DRAIN: if ((cnt_q == CNT_W'(1)) && !push_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Posted-write buffer storage
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
        wb_idx_q[i]  <= '0;
        wb_data_q[i] <= '0;
        wb_strb_q[i] <= '0;
      end
    end else if (push_c) begin
      wb_idx_q[wr_ptr_q]  <= idx_c;
      wb_data_q[wr_ptr_q] <= iob_wdata_i;
      wb_strb_q[wr_ptr_q] <= iob_wstrb_i;
    end
  end

  // Memory array. The head entry drains every cycle and only enabled byte lanes are updated.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < int'(MEM_D); i++) mem_q[i] <= '0;
    end else if (drain_c) begin
      for (int k = 0; k < int'(STRB_W); k++) begin
        if (wb_strb_q[rd_ptr_q][k])
          mem_q[wb_idx_q[rd_ptr_q]][8*k +: 8] <= wb_data_q[rd_ptr_q][8*k +: 8];
      end
    end
  end

  // Read pipeline. A stage holds zero data whenever it is not valid.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rv_q <= '0;
      for (int i = 0; i < int'(READ_LAT); i++) rd_q[i] <= '0;
    end else begin
      rv_q[0] <= rd_acc_c;
      rd_q[0] <= rd_acc_c ? mem_q[idx_c] : '0;
      for (int i = 1; i < int'(READ_LAT); i++) begin
        rv_q[i] <= rv_q[i-1];
        rd_q[i] <= rd_q[i-1];
      end
    end
  end

  assign iob_rvalid_o = rv_q[READ_LAT-1];
  assign iob_rdata_o  = rd_q[READ_LAT-1];

endmodule

// File: tb/tb_iob_mem_wrapper_wb.sv
// Directed bench for iob_mem_wrapper_wb.
// Three instances with READ_LAT 2 (main), 1 and 4 share the same inputs.
module tb_iob_mem_wrapper_wb;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [21:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        inv;
  logic        wtbe;

  logic [31:0] rdata2, rdata1, rdata4;
  logic        rv2, rv1, rv4;
  logic        rdy, rdy1, rdy4;
  logic        inv_o, inv_o1, inv_o4;
  logic        wtbe_o, wtbe_o1, wtbe_o4;

  int checks = 0;
  int errors = 0;
  logic [31:0] t4_exp [3];

  iob_mem_wrapper_wb #(.READ_LAT(2)) u_dut (
    .clk_i(clk), .arst_n_i(rst_n), .iob_valid_i(valid), .iob_addr_i(addr),
    .iob_wdata_i(wdata), .iob_wstrb_i(wstrb), .iob_rdata_o(rdata2), .iob_rvalid_o(rv2),
    .iob_ready_o(rdy), .invalidate_i(inv), .invalidate_o(inv_o),
    .wtb_empty_i(wtbe), .wtb_empty_o(wtbe_o));

  iob_mem_wrapper_wb #(.READ_LAT(1)) u_l1 (
    .clk_i(clk), .arst_n_i(rst_n), .iob_valid_i(valid), .iob_addr_i(addr),
    .iob_wdata_i(wdata), .iob_wstrb_i(wstrb), .iob_rdata_o(rdata1), .iob_rvalid_o(rv1),
    .iob_ready_o(rdy1), .invalidate_i(inv), .invalidate_o(inv_o1),
    .wtb_empty_i(wtbe), .wtb_empty_o(wtbe_o1));

  iob_mem_wrapper_wb #(.READ_LAT(4)) u_l4 (
    .clk_i(clk), .arst_n_i(rst_n), .iob_valid_i(valid), .iob_addr_i(addr),
    .iob_wdata_i(wdata), .iob_wstrb_i(wstrb), .iob_rdata_o(rdata4), .iob_rvalid_o(rv4),
    .iob_ready_o(rdy4), .invalidate_i(inv), .invalidate_o(inv_o4),
    .wtb_empty_i(wtbe), .wtb_empty_o(wtbe_o4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits up to 20 cycles for ready. A timeout is reported as a failed check.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    #1;
    while (!rdy && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(rdy), 32'd1);
  endtask

  task automatic wr(input logic [21:0] a, input logic [31:0] d, input logic [3:0] s);
    valid = 1'b1; addr = a; wdata = d; wstrb = s;
    wait_ready("wr_ready");
    tick();
    valid = 1'b0; wstrb = 4'h0;
  endtask

  // Read on the READ_LAT=2 instance. rvalid pulses in the second cycle after the accept.
  task automatic rd(input logic [21:0] a, input logic [31:0] exp, input string tag);
    valid = 1'b1; addr = a; wstrb = 4'h0;
    wait_ready({tag, "_ready"});
    tick();
    valid = 1'b0;
    chk({tag, "_rv_early"}, 32'(rv2), 32'd0);
    tick();
    chk({tag, "_rv"}, 32'(rv2), 32'd1);
    chk({tag, "_rdata"}, rdata2, exp);
    tick();
    chk({tag, "_rv_end"}, 32'(rv2), 32'd0);
    chk({tag, "_rdata_end"}, rdata2, 32'd0);
  endtask

  task automatic chk_lat(input int c, input int lat, input logic v, input logic [31:0] d);
    logic        want;
    logic [31:0] dexp;
    want = (c >= lat) && (c < lat + 3);
    dexp = want ? t4_exp[c-lat] : 32'd0;
    chk($sformatf("t4_l%0d_c%0d_rv", lat, c), 32'(v), 32'(want));
    chk($sformatf("t4_l%0d_c%0d_rdata", lat, c), d, dexp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0; inv = 1'b0; wtbe = 1'b1;
    tick();
    tick();
    // Reset state
    valid = 1'b1;
    #1;
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_rvalid", 32'(rv2), 32'd0);
    chk("rst_rdata", rdata2, 32'd0);
    chk("rst_wtbe", 32'(wtbe_o), 32'd1);
    chk("rst_inv", 32'(inv_o), 32'd0);
    valid = 1'b0;
    rst_n = 1'b1;
    #1;

    // T1: full-word write, then a read that stalls until the buffer drains
    valid = 1'b1; addr = 22'h0; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    #1;
    chk("t1_wr_ready", 32'(rdy), 32'd1);
    tick();
    wstrb = 4'h0;
    #1;
    chk("t1_rd_blocked", 32'(rdy), 32'd0);
    chk("t1_wtbe_busy", 32'(wtbe_o), 32'd0);
    tick();
    chk("t1_rd_ready", 32'(rdy), 32'd1);
    tick();
    valid = 1'b0;
    chk("t1_rv_early", 32'(rv2), 32'd0);
    tick();
    chk("t1_rv", 32'(rv2), 32'd1);
    chk("t1_rdata", rdata2, 32'hDEADBEEF);
    tick();
    chk("t1_rv_end", 32'(rv2), 32'd0);
    chk("t1_rdata_end", rdata2, 32'd0);

    // T2: partial writes
    do_reset();
    wr(22'h4, 32'hAABBCCDD, 4'b1100);
    rd(22'h4, 32'hAABB0000, "t2_hi");
    wr(22'h4, 32'hAABBCCDD, 4'b0011);
    rd(22'h4, 32'hAABBCCDD, "t2_lo");

    // T3: five back-to-back writes while the buffer drains
    valid = 1'b1; wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      addr = 22'(32'h40 + 4 * i);
      wdata = 32'hA5A50000 | 32'(i);
      #1;
      chk($sformatf("t3_ready_%0d", i), 32'(rdy), 32'd1);
      tick();
    end
    valid = 1'b0; wstrb = 4'h0;
    chk("t3_wtbe_pending", 32'(wtbe_o), 32'd0);
    tick();
    chk("t3_wtbe_rise", 32'(wtbe_o), 32'd1);
    for (int i = 0; i < 5; i++)
      rd(22'(32'h40 + 4 * i), 32'hA5A50000 | 32'(i), $sformatf("t3_rd%0d", i));

    // T4: back-to-back reads at READ_LAT 1, 2 and 4
    t4_exp[0] = 32'h11111111; t4_exp[1] = 32'h22222222; t4_exp[2] = 32'h33333333;
    wr(22'h0, t4_exp[0], 4'hF);
    wr(22'h4, t4_exp[1], 4'hF);
    wr(22'h8, t4_exp[2], 4'hF);
    valid = 1'b1; wstrb = 4'h0; addr = 22'h0;
    wait_ready("t4_ready");
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) addr = 22'h4;
      else if (c == 2) addr = 22'h8;
      else if (c == 3) begin valid = 1'b0; addr = 22'h0; end
      chk_lat(c, 1, rv1, rdata1);
      chk_lat(c, 2, rv2, rdata2);
      chk_lat(c, 4, rv4, rdata4);
    end

    // T5: address aliasing, with invalidate toggled around the write
    inv = 1'b1;
    #1;
    chk("t5_inv_hi", 32'(inv_o), 32'd1);
    wr(22'h1008, 32'h12345678, 4'hF);
    inv = 1'b0;
    #1;
    chk("t5_inv_lo", 32'(inv_o), 32'd0);
    rd(22'h8, 32'h12345678, "t5_alias");
    rd(22'h1000, 32'h11111111, "t5_alias0");

    // T6: reset with a write buffered and a read in flight
    valid = 1'b1; wstrb = 4'h0; addr = 22'h0;
    wait_ready("t6_ready");
    tick();
    wstrb = 4'hF; wdata = 32'hCAFEF00D; addr = 22'hC;
    tick();
    wdata = 32'h0BADBEEF; addr = 22'h14;
    tick();
    chk("t6_l4_inflight", 32'(rv4), 32'd0);
    rst_n = 1'b0; wstrb = 4'h0;
    #1;
    chk("t6_rst_ready", 32'(rdy), 32'd0);
    chk("t6_rst_rv2", 32'(rv2), 32'd0);
    chk("t6_rst_rv4", 32'(rv4), 32'd0);
    chk("t6_rst_rdata4", rdata4, 32'd0);
    chk("t6_rst_wtbe", 32'(wtbe_o), 32'd1);
    wtbe = 1'b0; inv = 1'b1;
    #1;
    chk("t6_wtbe_follow0", 32'(wtbe_o), 32'd0);
    chk("t6_inv_follow1", 32'(inv_o), 32'd1);
    wtbe = 1'b1; inv = 1'b0;
    #1;
    chk("t6_wtbe_follow1", 32'(wtbe_o), 32'd1);
    chk("t6_inv_follow0", 32'(inv_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t6_inrst_rv4_%0d", i), 32'(rv4), 32'd0);
    end
    valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t6_post_rv4_%0d", i), 32'(rv4), 32'd0);
      chk($sformatf("t6_post_rv2_%0d", i), 32'(rv2), 32'd0);
    end
    rd(22'hC, 32'd0, "t6_mem_c");
    rd(22'h14, 32'd0, "t6_mem_14");
    rd(22'h0, 32'd0, "t6_mem_0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
